// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a 1-cycle-latency sprite ROM and turns each opaque,
// on-screen palette index into a framebuffer write at (pos_x+col, pos_y+row).
module sprite_blitter #(
  parameter int unsigned SPR_W  = 60,
  parameter int unsigned SPR_H  = 60,
  parameter int unsigned SCR_W  = 640,
  parameter int unsigned SCR_H  = 480,
  parameter logic [4:0]  TRANSP = 5'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic        busy,
  output logic        done,
  output logic [11:0] rom_addr,
  input  logic [4:0]  rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [4:0]  fb_data,
  input  logic        fb_ready
);

  localparam int unsigned NPIX = SPR_W * SPR_H;
  localparam int unsigned AW   = 12;
  localparam int unsigned CW   = 6;
  localparam int unsigned RW   = 6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [9:0]      px_q, px_d, py_q, py_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [CW-1:0]   s1_col_q, s1_col_d;
  logic [RW-1:0]   s1_row_q, s1_row_d;
  logic [AW-1:0]   s1_addr_q, s1_addr_d;
  logic            fb_we_q, fb_we_d;
  logic [18:0]     fb_addr_q, fb_addr_d;
  logic [4:0]      fb_data_q, fb_data_d;

  logic            stall;
  logic [10:0]     x_sum, y_sum;
  logic            wr_ok;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s1_addr_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      px_q       <= px_d;
      py_q       <= py_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      s1_valid_q <= s1_valid_d;
      s1_col_q   <= s1_col_d;
      s1_row_q   <= s1_row_d;
      s1_addr_q  <= s1_addr_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
    end
  end

  // Next-state, issue and output-register logic; a stall freezes everything.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    px_d       = px_q;
    py_d       = py_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    s1_valid_d = s1_valid_q;
    s1_col_d   = s1_col_q;
    s1_row_d   = s1_row_q;
    s1_addr_d  = s1_addr_q;
    fb_we_d    = fb_we_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;

    stall = fb_we_q && !fb_ready;
    x_sum = 11'(px_q) + 11'(s1_col_q);
    y_sum = 11'(py_q) + 11'(s1_row_q);
    wr_ok = s1_valid_q && (rom_data != TRANSP) &&
            (x_sum < 11'(SCR_W)) && (y_sum < 11'(SCR_H));

    if (!stall) begin
      fb_we_d    = wr_ok;
      fb_addr_d  = 19'(y_sum) * 19'(SCR_W) + 19'(x_sum);
      fb_data_d  = rom_data;
      s1_valid_d = 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            px_d    = pos_x;
            py_d    = pos_y;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          s1_valid_d = 1'b1;
          s1_col_d   = col_q;
          s1_row_d   = row_q;
          s1_addr_d  = addr_q;
          if (addr_q == AW'(NPIX - 1)) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
            if (col_q == CW'(SPR_W - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
        // Output register retires this cycle (not stalled); wait for stage 1.
        S_DRAIN: if (!s1_valid_q) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
    end
  end

  // During a stall re-read the stage-1 pixel so rom_data stays valid for it.
  assign rom_addr = stall ? s1_addr_q : addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a ROM model feeds the DUT, expected
// framebuffer writes are queued at start and popped as writes are accepted.
module tb_sprite_blitter;

  localparam int NPIX = 3600;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic        busy, done, fb_we;
  logic [11:0] rom_addr;
  logic [4:0]  rom_data = '0;
  logic [18:0] fb_addr;
  logic [4:0]  fb_data;
  logic        fb_ready = 1'b1;

  logic [4:0]  rom_mem [0:NPIX-1];
  logic [23:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  sprite_blitter dut (
    .Clk(Clk), .Reset(Reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk)
    rom_data <= (rom_addr < 12'(NPIX)) ? rom_mem[rom_addr] : 5'h00;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_rom(input int pattern, input int val);
    for (int i = 0; i < NPIX; i++)
      rom_mem[i] = pattern ? 5'((i * 7 + 3) % 32) : 5'(val);
  endtask

  // One draw from start to done; negative expectations are skipped.
  task automatic draw(input string nm, input int px, input int py,
                      input int stall_len, input int restart_at, input int reset_at,
                      input int exp_first_c, input int exp_last_c,
                      input int exp_first_addr, input int exp_last_addr, input int exp_max);
    int c, acc, we_cycles, busy_cycles, done_c, first_c, last_c, stall_left, exp_n;
    int first_addr, last_addr, max_addr;
    logic stalled_prev;
    logic [18:0] prev_addr;
    logic [4:0]  prev_data;
    logic [23:0] e;

    exp_q.delete();
    for (int r = 0; r < 60; r++)
      for (int col = 0; col < 60; col++) begin
        int x, y;
        logic [4:0] d;
        d = rom_mem[r * 60 + col];
        x = px + col;
        y = py + r;
        if (d != 5'h00 && x < 640 && y < 480) exp_q.push_back({19'(y * 640 + x), d});
      end
    exp_n = exp_q.size();
    acc = 0; we_cycles = 0; busy_cycles = 0; done_c = -1; first_c = -1; last_c = -1;
    first_addr = -1; last_addr = -1; max_addr = -1;
    stall_left = stall_len; stalled_prev = 1'b0; prev_addr = '0; prev_data = '0;

    @(negedge Clk);
    start = 1'b1; pos_x = 10'(px); pos_y = 10'(py); fb_ready = 1'b1;
    @(posedge Clk);
    c = 1;
    while (c <= 5000) begin
      @(negedge Clk);
      start = (c == restart_at);
      if (c == restart_at) begin pos_x = 10'd300; pos_y = 10'd5; end
      if (fb_we && acc == 9 && stall_left > 0) begin
        fb_ready = 1'b0;
        stall_left--;
      end else fb_ready = 1'b1;
      if (c == reset_at) Reset = 1'b1;
      #1;
      if (c == 1) begin
        check_eq({nm, "_rom_addr_c1"}, rom_addr, 0);
        check_eq({nm, "_busy_c1"}, busy, 1);
      end
      if (busy) busy_cycles++;
      if (stalled_prev) begin
        check_eq({nm, "_stall_we_hold"}, fb_we, 1);
        check_eq({nm, "_stall_addr_hold"}, fb_addr, prev_addr);
        check_eq({nm, "_stall_data_hold"}, fb_data, prev_data);
      end
      if (fb_we) begin
        we_cycles++;
        if (fb_ready) begin
          if (first_c < 0) begin first_c = c; first_addr = int'(fb_addr); end
          last_c = c;
          last_addr = int'(fb_addr);
          if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
          if (exp_q.size() == 0) check_eq({nm, "_extra_write"}, fb_addr, -1);
          else begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s_wr%0d_addr", nm, acc), fb_addr, e[23:5]);
            check_eq($sformatf("%s_wr%0d_data", nm, acc), fb_data, e[4:0]);
          end
          acc++;
        end
      end
      stalled_prev = fb_we && !fb_ready;
      prev_addr = fb_addr;
      prev_data = fb_data;
      if (c == reset_at) begin
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_eq({nm, "_rst_busy"}, busy, 0);
        check_eq({nm, "_rst_fb_we"}, fb_we, 0);
        check_eq({nm, "_rst_done"}, done, 0);
        for (int k = 0; k < 5; k++) begin
          @(negedge Clk);
          check_eq({nm, "_post_rst_we"}, fb_we, 0);
        end
        return;
      end
      if (done) begin done_c = c; break; end
      c++;
    end
    if (done_c < 0) check_eq({nm, "_timeout"}, 0, 1);
    check_eq({nm, "_done_cycle"}, done_c, 3603 + stall_len);
    check_eq({nm, "_busy_cycles"}, busy_cycles, 3602 + stall_len);
    check_eq({nm, "_writes"}, acc, exp_n);
    check_eq({nm, "_we_cycles"}, we_cycles, exp_n + stall_len);
    check_eq({nm, "_queue_left"}, exp_q.size(), 0);
    if (exp_first_c >= 0)    check_eq({nm, "_first_cycle"}, first_c, exp_first_c);
    if (exp_last_c >= 0)     check_eq({nm, "_last_cycle"}, last_c, exp_last_c);
    if (exp_first_addr >= 0) check_eq({nm, "_first_addr"}, first_addr, exp_first_addr);
    if (exp_last_addr >= 0)  check_eq({nm, "_last_addr"}, last_addr, exp_last_addr);
    if (exp_max >= 0)        check_eq({nm, "_max_addr"}, max_addr, exp_max);
    @(negedge Clk);
    check_eq({nm, "_done_pulse_end"}, done, 0);
    check_eq({nm, "_idle_busy"}, busy, 0);
    check_eq({nm, "_idle_we"}, fb_we, 0);
  endtask

  initial begin
    fill_rom(0, 7);
    repeat (3) @(negedge Clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_fb_we", fb_we, 0);
    check_eq("reset_fb_addr", fb_addr, 0);
    check_eq("reset_fb_data", fb_data, 0);
    check_eq("reset_rom_addr", rom_addr, 0);
    Reset = 1'b0;
    @(negedge Clk);
    check_eq("idle_hold_busy", busy, 0);

    fill_rom(0, 7);
    draw("solid", 0, 0, 0, -1, -1, 3, 3602, 0, 59 * 640 + 59, -1);
    fill_rom(0, 0);
    draw("transp", 100, 100, 0, -1, -1, -1, -1, -1, -1, -1);
    fill_rom(0, 31);
    draw("clip", 600, 450, 0, -1, -1, -1, -1, -1, -1, 307199);
    check_eq("clip_count_model", 0, 0 * 1);
    fill_rom(1, 0);
    draw("stall", 0, 0, 3, -1, -1, -1, -1, -1, -1, -1);
    draw("restart", 0, 0, 0, 500, -1, -1, -1, -1, -1, -1);
    fill_rom(0, 7);
    draw("pos10_20", 10, 20, 0, -1, -1, 3, -1, 12810, -1, -1);
    fill_rom(1, 0);
    draw("reset_mid", 50, 60, 0, -1, 1000, -1, -1, -1, -1, -1);
    draw("after_rst", 0, 0, 0, -1, -1, -1, -1, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
